sys_ctrl_ext: RTL and testbench

Parametrised successor to the system control register block on the SPI IOC register bus.
- Keeps the read-only identity registers and the debug-mode control bits.
- Adds: readable and wider debug modes, sticky error capture with write-1-to-clear, an error interrupt mask, a scratch register, a timed soft-reset pulse generator, and a free-running uptime counter with atomic multi-byte snapshot.
- Sits beside the other IOC-addressed modules; selected by i_cs from the address decoder.

---
 rtl/sys_ctrl_ext.sv | 190 +++++++++++++++++++
 tb/tb_sys_ctrl_ext.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_ext.sv
// sys_ctrl_ext: system control register block on the SPI IOC register bus.
// Holds the read-only identity registers, debug-mode bits, sticky error
// capture with write-1-to-clear and interrupt mask, a scratch register,
// a timed soft-reset pulse generator and a free-running uptime counter
// whose upper bytes are read from a snapshot taken when byte 0 is read.
module sys_ctrl_ext #(
    parameter int          DEBUG_W        = 3,
    parameter int          NUM_ERR        = 4,
    parameter int          SRST_CYCLES    = 16,
    parameter int          UPTIME_BYTES   = 4,
    parameter logic [7:0]  MODULE_VERSION = 8'h02,
    parameter logic [7:0]  SYSTEM_VERSION = 8'h01,
    parameter logic [7:0]  MANU_ID        = 8'h01
) (
    input  logic               i_sys_clk,
    input  logic               i_rst_b,
    input  logic [4:0]         i_ioc,
    input  logic [7:0]         i_data_in,
    output logic [7:0]         o_data_out,
    input  logic               i_cs,
    input  logic               i_fetch_cmd,
    input  logic               i_load_cmd,
    input  logic [NUM_ERR-1:0] i_err,
    output logic [DEBUG_W-1:0] o_debug,
    output logic               o_err_irq,
    output logic               o_soft_rst_b
);

    localparam int UPT_W = 8 * UPTIME_BYTES;

    localparam logic [4:0] IOC_MOD_VER = 5'h00;
    localparam logic [4:0] IOC_SYS_VER = 5'h01;
    localparam logic [4:0] IOC_MANU_ID = 5'h02;
    localparam logic [4:0] IOC_ERR     = 5'h03;
    localparam logic [4:0] IOC_ERR_CLR = 5'h04;
    localparam logic [4:0] IOC_DEBUG   = 5'h05;
    localparam logic [4:0] IOC_SCRATCH = 5'h06;
    localparam logic [4:0] IOC_SRST    = 5'h07;
    localparam logic [4:0] IOC_UPT0    = 5'h08;
    localparam logic [4:0] IOC_UPT1    = 5'h09;
    localparam logic [4:0] IOC_UPT2    = 5'h0A;
    localparam logic [4:0] IOC_UPT3    = 5'h0B;
    localparam logic [4:0] IOC_MASK    = 5'h0C;

    localparam logic [7:0]       SRST_KEY  = 8'hA5;
    localparam logic [7:0]       SRST_LOAD = 8'(SRST_CYCLES - 1);
    localparam logic [UPT_W-1:0] UPT_ONE   = UPT_W'(1);

    typedef enum logic [0:0] {
        SRST_IDLE  = 1'b0,
        SRST_PULSE = 1'b1
    } srst_state_t;

    logic               fetch_p0;
    logic               load_p0;
    logic [NUM_ERR-1:0] sticky;
    logic [NUM_ERR-1:0] mask;
    logic [NUM_ERR-1:0] err_clr;
    logic [7:0]         scratch;
    logic [UPT_W-1:0]   uptime;
    logic [UPT_W-1:0]   snapshot;
    logic [1:0]         byte_idx;
    logic               byte_in_range;
    logic [7:0]         rd_data;
    logic               srst_arm;
    srst_state_t        srst_state;
    logic [7:0]         srst_cnt;

    // Bus command decode: fetch wins over a simultaneous load
    always_comb begin
        fetch_p0      = i_cs & i_fetch_cmd;
        load_p0       = i_cs & i_load_cmd & ~i_fetch_cmd;
        srst_arm      = load_p0 && (i_ioc == IOC_SRST) && (i_data_in == SRST_KEY);
        err_clr       = (load_p0 && (i_ioc == IOC_ERR_CLR)) ? i_data_in[NUM_ERR-1:0] : '0;
        byte_idx      = i_ioc[1:0];
        byte_in_range = (32'(byte_idx) < UPTIME_BYTES);
    end

    // Read data multiplexer; unmapped indices read as zero
    always_comb begin
        rd_data = '0;
        case (i_ioc)
            IOC_MOD_VER: rd_data = MODULE_VERSION;
            IOC_SYS_VER: rd_data = SYSTEM_VERSION;
            IOC_MANU_ID: rd_data = MANU_ID;
            IOC_ERR:     rd_data[NUM_ERR-1:0] = sticky;
            IOC_DEBUG:   rd_data[DEBUG_W-1:0] = o_debug;
            IOC_SCRATCH: rd_data = scratch;
            IOC_UPT0, IOC_UPT1, IOC_UPT2, IOC_UPT3: begin
                if (byte_in_range) begin
                    if (i_ioc == IOC_UPT0) begin
                        rd_data = uptime[7:0];
                    end else begin
                        rd_data = snapshot[{byte_idx, 3'b000} +: 8];
                    end
                end
            end
            IOC_MASK:    rd_data[NUM_ERR-1:0] = mask;
            default:     rd_data = '0;
        endcase
    end

    // Registered read port: updates on a fetch, holds otherwise
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_data_out <= '0;
        end else if (fetch_p0) begin
            o_data_out <= rd_data;
        end
    end

    // Writable control registers: debug modes, scratch, error mask
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_debug <= '0;
            scratch <= '0;
            mask    <= '1;
        end else if (load_p0) begin
            case (i_ioc)
                IOC_DEBUG:   o_debug <= i_data_in[DEBUG_W-1:0];
                IOC_SCRATCH: scratch <= i_data_in;
                IOC_MASK:    mask    <= i_data_in[NUM_ERR-1:0];
                default:     ;
            endcase
        end
    end

    // Sticky error capture, independent of chip select; a new error beats a clear
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sticky <= '0;
        end else begin
            sticky <= i_err | (sticky & ~err_clr);
        end
    end

    // Error interrupt from the registered sticky bits, one cycle behind them
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_err_irq <= 1'b0;
        end else begin
            o_err_irq <= |(sticky & mask);
        end
    end

    // Free-running uptime counter with snapshot taken on a read of byte 0
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            uptime   <= '0;
            snapshot <= '0;
        end else begin
            uptime <= uptime + UPT_ONE;
            if (fetch_p0 && (i_ioc == IOC_UPT0)) begin
                snapshot <= uptime;
            end
        end
    end

    // Soft-reset pulse generator: fixed-length low pulse, no retrigger while active
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            srst_state   <= SRST_IDLE;
            srst_cnt     <= '0;
            o_soft_rst_b <= 1'b1;
        end else begin
            case (srst_state)
                SRST_IDLE: begin
                    if (srst_arm) begin
                        srst_state   <= SRST_PULSE;
                        srst_cnt     <= SRST_LOAD;
                        o_soft_rst_b <= 1'b0;
                    end
                end
                SRST_PULSE: begin
                    if (srst_cnt == 8'd0) begin
                        srst_state   <= SRST_IDLE;
                        o_soft_rst_b <= 1'b1;
                    end else begin
                        srst_cnt <= srst_cnt - 8'd1;
                    end
                end
                default: begin
                    srst_state   <= SRST_IDLE;
                    o_soft_rst_b <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_ext.sv
// Testbench for sys_ctrl_ext: table of directed bus vectors plus
// hand-written sequences for errors, soft reset, uptime and async reset.
module tb_sys_ctrl_ext;

    logic       clk;
    logic       rst_b;
    logic [4:0] ioc;
    logic [7:0] din;
    logic       cs;
    logic       fetch;
    logic       load;
    logic [3:0] err;
    logic [7:0] dout;
    logic [2:0] debug;
    logic       irq;
    logic       srst_b;

    // second instance with a one-byte uptime counter for the wrap check
    logic [4:0] ioc2;
    logic       fetch2;
    logic [3:0] err2;
    logic [7:0] dout2;
    logic [2:0] debug2;
    logic       irq2;
    logic       srst2_b;

    int n_cmp;
    int n_fail;
    int unsigned edges;

    sys_ctrl_ext dut (
        .i_sys_clk   (clk),
        .i_rst_b     (rst_b),
        .i_ioc       (ioc),
        .i_data_in   (din),
        .o_data_out  (dout),
        .i_cs        (cs),
        .i_fetch_cmd (fetch),
        .i_load_cmd  (load),
        .i_err       (err),
        .o_debug     (debug),
        .o_err_irq   (irq),
        .o_soft_rst_b(srst_b)
    );

    sys_ctrl_ext #(.UPTIME_BYTES(1)) dut8 (
        .i_sys_clk   (clk),
        .i_rst_b     (rst_b),
        .i_ioc       (ioc2),
        .i_data_in   (8'h00),
        .o_data_out  (dout2),
        .i_cs        (1'b1),
        .i_fetch_cmd (fetch2),
        .i_load_cmd  (1'b0),
        .i_err       (err2),
        .o_debug     (debug2),
        .o_err_irq   (irq2),
        .o_soft_rst_b(srst2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference count of clock edges since reset release (expected uptime)
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) edges <= 0;
        else        edges <= edges + 1;
    end

    typedef struct {
        logic       cs;
        logic       f;
        logic       l;
        logic [4:0] ioc;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic [2:0] exp_debug;
        logic       exp_srst;
        string      name;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic c, input logic f, input logic l, input logic [4:0] a,
                       input logic [7:0] d, input logic [7:0] ed, input logic [2:0] edb,
                       input logic es, input string nm);
        vec_t v;
        v.cs = c; v.f = f; v.l = l; v.ioc = a; v.din = d;
        v.exp_data = ed; v.exp_debug = edb; v.exp_srst = es; v.name = nm;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        cs = 1'b0; fetch = 1'b0; load = 1'b0; ioc = '0; din = '0;
    endtask

    task automatic do_load(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; fetch = 1'b0; load = 1'b1; ioc = a; din = d;
        tick();
        idle();
    endtask

    task automatic do_fetch(input logic [4:0] a);
        cs = 1'b1; fetch = 1'b1; load = 1'b0; ioc = a; din = '0;
        tick();
        idle();
    endtask

    initial begin
        int low_cnt;
        int budget;
        logic [7:0] exp_live;

        n_cmp = 0; n_fail = 0;
        idle();
        err = '0; err2 = '0; ioc2 = '0; fetch2 = 1'b0;
        rst_b = 1'b0;
        #23;
        check("reset_data",  {24'h0, dout}, 32'h00);
        check("reset_debug", {29'h0, debug}, 32'h0);
        check("reset_irq",   {31'h0, irq}, 32'h0);
        check("reset_srst",  {31'h0, srst_b}, 32'h1);
        rst_b = 1'b1;
        tick();

        //  cs  f  l  ioc    din    data   dbg  srst
        add(1, 1, 0, 5'h00, 8'h00, 8'h02, 3'h0, 1, "rd_modver");
        add(1, 1, 0, 5'h01, 8'h00, 8'h01, 3'h0, 1, "rd_sysver");
        add(1, 1, 0, 5'h02, 8'h00, 8'h01, 3'h0, 1, "rd_manuid");
        add(1, 1, 0, 5'h1F, 8'h00, 8'h00, 3'h0, 1, "rd_unmapped");
        add(0, 1, 0, 5'h00, 8'h00, 8'h00, 3'h0, 1, "rd_no_cs");
        add(1, 0, 1, 5'h05, 8'hFF, 8'h00, 3'h7, 1, "wr_debug");
        add(1, 1, 0, 5'h05, 8'h00, 8'h07, 3'h7, 1, "rd_debug");
        add(1, 1, 1, 5'h06, 8'h55, 8'h00, 3'h7, 1, "fetch_load_same");
        add(1, 1, 0, 5'h06, 8'h00, 8'h00, 3'h7, 1, "rd_scratch_kept");
        add(1, 0, 1, 5'h06, 8'hA5, 8'h00, 3'h7, 1, "wr_scratch");
        add(1, 1, 0, 5'h06, 8'h00, 8'hA5, 3'h7, 1, "rd_scratch");
        add(1, 0, 0, 5'h00, 8'h00, 8'hA5, 3'h7, 1, "hold_data");
        add(0, 0, 1, 5'h05, 8'h01, 8'hA5, 3'h7, 1, "wr_no_cs");
        add(1, 0, 1, 5'h05, 8'h02, 8'hA5, 3'h2, 1, "wr_debug2");
        add(1, 1, 0, 5'h05, 8'h00, 8'h02, 3'h2, 1, "rd_debug2");
        add(1, 1, 0, 5'h0C, 8'h00, 8'h0F, 3'h2, 1, "rd_mask_rst");
        add(1, 1, 0, 5'h04, 8'h00, 8'h00, 3'h2, 1, "rd_errclr_wo");
        add(1, 1, 0, 5'h03, 8'h00, 8'h00, 3'h2, 1, "rd_err_none");
        add(1, 1, 0, 5'h09, 8'h00, 8'h00, 3'h2, 1, "rd_snap_rst");
        add(1, 0, 1, 5'h13, 8'hFF, 8'h00, 3'h2, 1, "wr_unmapped");
        add(1, 1, 0, 5'h13, 8'h00, 8'h00, 3'h2, 1, "rd_unmapped2");
        add(1, 0, 1, 5'h07, 8'h12, 8'h00, 3'h2, 1, "srst_bad_key");
        add(1, 1, 0, 5'h07, 8'h00, 8'h00, 3'h2, 1, "srst_no_pulse");

        for (int i = 0; i < vt.size(); i++) begin
            cs = vt[i].cs; fetch = vt[i].f; load = vt[i].l;
            ioc = vt[i].ioc; din = vt[i].din;
            tick();
            idle();
            check({vt[i].name, "_data"},  {24'h0, dout},   {24'h0, vt[i].exp_data});
            check({vt[i].name, "_debug"}, {29'h0, debug},  {29'h0, vt[i].exp_debug});
            check({vt[i].name, "_srst"},  {31'h0, srst_b}, {31'h0, vt[i].exp_srst});
        end

        // sticky error capture and interrupt
        err = 4'b0100;
        tick();
        err = 4'b0000;
        check("irq_lags_sticky", {31'h0, irq}, 32'h0);
        do_fetch(5'h03);
        check("err_sticky", {24'h0, dout}, 32'h04);
        check("err_irq_set", {31'h0, irq}, 32'h1);
        do_load(5'h0C, 8'h00);
        tick();
        check("err_irq_masked", {31'h0, irq}, 32'h0);
        do_fetch(5'h0C);
        check("rd_mask_zero", {24'h0, dout}, 32'h00);
        err = 4'b0100;
        do_load(5'h04, 8'h04);
        err = 4'b0000;
        do_fetch(5'h03);
        check("err_set_beats_clr", {24'h0, dout}, 32'h04);
        do_load(5'h04, 8'hF4);
        do_fetch(5'h03);
        check("err_cleared", {24'h0, dout}, 32'h00);

        // soft-reset pulse width and no retrigger
        do_load(5'h07, 8'hA5);
        check("srst_start", {31'h0, srst_b}, 32'h0);
        low_cnt = 1;
        for (int i = 1; i <= 24; i++) begin
            if (i == 5) begin
                cs = 1'b1; load = 1'b1; ioc = 5'h07; din = 8'hA5;
            end
            tick();
            idle();
            if (srst_b == 1'b0) low_cnt++;
        end
        check("srst_width", low_cnt, 16);
        check("srst_end", {31'h0, srst_b}, 32'h1);

        // uptime live byte, snapshot of upper bytes
        budget = 2000;
        while (edges != 32'h1FF && budget > 0) begin
            tick();
            budget--;
        end
        check("uptime_reach", edges, 32'h1FF);
        do_fetch(5'h08);
        check("uptime_b0_live", {24'h0, dout}, 32'hFF);
        repeat (10) tick();
        do_fetch(5'h09);
        check("uptime_b1_snap", {24'h0, dout}, 32'h01);
        do_fetch(5'h0A);
        check("uptime_b2_snap", {24'h0, dout}, 32'h00);
        do_fetch(5'h0B);
        check("uptime_b3_snap", {24'h0, dout}, 32'h00);
        exp_live = 8'(edges);
        do_fetch(5'h08);
        check("uptime_b0_live2", {24'h0, dout}, {24'h0, exp_live});

        // one-byte counter wraps to zero; byte 1 does not exist
        budget = 600;
        while (edges[7:0] != 8'hFF && budget > 0) begin
            tick();
            budget--;
        end
        ioc2 = 5'h08; fetch2 = 1'b1;
        tick();
        check("upt8_ff", {24'h0, dout2}, 32'hFF);
        tick();
        check("upt8_wrap", {24'h0, dout2}, 32'h00);
        ioc2 = 5'h09;
        tick();
        fetch2 = 1'b0;
        check("upt8_b1_zero", {24'h0, dout2}, 32'h00);

        // asynchronous reset in the middle of a soft-reset pulse
        do_load(5'h0C, 8'h0F);
        do_load(5'h05, 8'h05);
        err = 4'b1010;
        tick();
        err = 4'b0000;
        do_load(5'h07, 8'hA5);
        tick();
        tick();
        check("pre_rst_srst",  {31'h0, srst_b}, 32'h0);
        check("pre_rst_irq",   {31'h0, irq}, 32'h1);
        check("pre_rst_debug", {29'h0, debug}, 32'h5);
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_srst",  {31'h0, srst_b}, 32'h1);
        check("arst_irq",   {31'h0, irq}, 32'h0);
        check("arst_debug", {29'h0, debug}, 32'h0);
        check("arst_data",  {24'h0, dout}, 32'h00);
        #3;
        rst_b = 1'b1;
        tick();
        do_fetch(5'h03);
        check("arst_sticky", {24'h0, dout}, 32'h00);
        do_fetch(5'h0C);
        check("arst_mask", {24'h0, dout}, 32'h0F);
        check("arst_srst_idle", {31'h0, srst_b}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
